// File: rtl/fp_normalize_round_seq.sv
// fp_normalize_round_seq
//   Sequential normalise-and-round stage for the FP multiplier datapath.
//   Takes a double-width mantissa product (2 integer bits) with a biased,
//   signed, pre-normalisation exponent; normalises it one shift per cycle,
//   rounds it under one of four IEEE modes and holds the packed result
//   until the consumer accepts it.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         input handshake (in_ready = block idle)
//   in_sign, in_exp, in_mant    sign, signed biased exponent, raw product
//   in_rmode                    00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   out_valid / out_ready       output handshake
//   out_sign, out_exp, out_frac packed result
//   out_overflow, out_underflow, out_inexact, out_zero  exception flags
module fp_normalize_round_seq #(
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W+1:0]      in_exp,
  input  logic [2*FRAC_W+1:0]   in_mant,
  input  logic [1:0]            in_rmode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_W-1:0]      out_exp,
  output logic [FRAC_W-1:0]     out_frac,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic                  out_inexact,
  output logic                  out_zero
);

  localparam int unsigned IN_W  = 2*FRAC_W+2;
  // One guard bit above the EXP_W+2 input range: the single overflow
  // right-shift plus the rounding carry can push e past the top of the
  // input range, and it must not wrap into the flush region.
  localparam int unsigned EI_W  = EXP_W+3;
  localparam int unsigned SUM_W = FRAC_W+2;

  localparam logic signed [EI_W-1:0] E_ONE   = EI_W'(1);
  localparam logic signed [EI_W-1:0] E_FLUSH = EI_W'(-(int'(FRAC_W) + 1));
  localparam logic signed [EI_W-1:0] E_OVF   = EI_W'((1 << EXP_W) - 1);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [1:0]              rm_q, rm_d;
  logic signed [EI_W-1:0]  e_q, e_d;
  logic [IN_W-1:0]         m_q, m_d;
  logic                    sr_q, sr_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    osign_q, osign_d;
  logic [EXP_W-1:0]        oexp_q, oexp_d;
  logic [FRAC_W-1:0]       ofrac_q, ofrac_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    inx_q, inx_d;
  logic                    zero_q, zero_d;

  // Rounding datapath, evaluated on the aligned mantissa
  logic [FRAC_W:0]         kept;
  logic                    guard, sticky, inc;
  logic [SUM_W-1:0]        sum_raw, sum;
  logic signed [EI_W-1:0]  e_rnd;
  logic                    ovf, hidden, inexact;

  always_comb begin
    kept    = m_q[IN_W-2:FRAC_W];
    guard   = m_q[FRAC_W-1];
    sticky  = (|m_q[FRAC_W-2:0]) | sr_q;
    case (rm_q)
      RM_RNE:  inc = guard & (sticky | kept[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign_q & (guard | sticky);
      default: inc = sign_q & (guard | sticky);
    endcase
    sum_raw = SUM_W'(kept) + SUM_W'(inc);
    // Carry out of the hidden bit renormalises by one position
    if (sum_raw[SUM_W-1]) begin
      sum   = sum_raw >> 1;
      e_rnd = e_q + E_ONE;
    end else begin
      sum   = sum_raw;
      e_rnd = e_q;
    end
    inexact = guard | sticky;
    ovf     = (e_rnd >= E_OVF);
    hidden  = sum[FRAC_W];
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    rm_d        = rm_q;
    e_d         = e_q;
    m_d         = m_q;
    sr_d        = sr_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    osign_d     = osign_q;
    oexp_d      = oexp_q;
    ofrac_d     = ofrac_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = in_sign;
          e_d        = EI_W'($signed(in_exp));
          m_d        = in_mant;
          rm_d       = in_rmode;
          sr_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ALIGN;
        end
      end

      // One normalisation action per cycle, highest priority first
      ALIGN: begin
        if (m_q == '0) begin
          state_d = ROUND;
        end else if (e_q < E_FLUSH) begin
          sr_d = sr_q | (|m_q);
          m_d  = '0;
          e_d  = E_ONE;
        end else if (m_q[IN_W-1] || (e_q < E_ONE)) begin
          m_d  = m_q >> 1;
          sr_d = sr_q | m_q[0];
          e_d  = e_q + E_ONE;
        end else if (!m_q[IN_W-2] && (e_q > E_ONE)) begin
          m_d  = m_q << 1;
          e_d  = e_q - E_ONE;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        osign_d = sign_q;
        if (ovf) begin
          oexp_d  = '1;
          ofrac_d = '0;
          ovf_d   = 1'b1;
          inx_d   = 1'b1;
        end else begin
          oexp_d  = hidden ? e_rnd[EXP_W-1:0] : '0;
          ofrac_d = sum[FRAC_W-1:0];
          ovf_d   = 1'b0;
          inx_d   = inexact;
        end
        unf_d       = ~hidden & inexact;
        zero_d      = (sum == '0) & ~ovf;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      rm_q        <= '0;
      e_q         <= '0;
      m_q         <= '0;
      sr_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      osign_q     <= 1'b0;
      oexp_q      <= '0;
      ofrac_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      rm_q        <= rm_d;
      e_q         <= e_d;
      m_q         <= m_d;
      sr_q        <= sr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      osign_q     <= osign_d;
      oexp_q      <= oexp_d;
      ofrac_q     <= ofrac_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_sign      = osign_q;
  assign out_exp       = oexp_q;
  assign out_frac      = ofrac_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;
  assign out_zero      = zero_q;

endmodule
